// File: rtl/regfile_param.sv
// -----------------------------------------------------------------------------
// regfile_param
//    Parametrised decode-stage register bank. Combinational multi-port read,
//    single write port, optional hardwired entry 0 and optional write-to-read
//    bypass. After reset a clear sequencer zeroes one entry per cycle so the
//    contents are defined on silicon; during that sequence the bank is busy.
//
// Ports
//    clk      in   clock, all state updates on rising edge
//    reset    in   synchronous, active-high
//    we       in   write enable
//    waddr    in   [ADDR_W]          write address
//    wdata    in   [DATA_W]          write data
//    raddr    in   [NUM_RD*ADDR_W]   read addresses, port i at [i*ADDR_W +: ADDR_W]
//    rdata    out  [NUM_RD*DATA_W]   read data, port i at [i*DATA_W +: DATA_W]
//    busy     out  clear sequence in progress (writes ignored, reads return 0)
//    wr_drop  out  one-cycle pulse: previous-cycle write rejected while busy
// -----------------------------------------------------------------------------
module regfile_param #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 5,
   parameter int NUM_RD         = 2,
   parameter int ZERO_REG       = 1,
   parameter int BYPASS         = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       we,
   input  logic [ADDR_W-1:0]          waddr,
   input  logic [DATA_W-1:0]          wdata,
   input  logic [NUM_RD*ADDR_W-1:0]   raddr,
   output logic [NUM_RD*DATA_W-1:0]   rdata,
   output logic                       busy,
   output logic                       wr_drop
);

   localparam int DEPTH = 2**ADDR_W;
   // Pointer is one bit wider than the address so the final entry index is
   // compared without any overflow ambiguity.
   localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH-1);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W:0]     ptr_q, ptr_d;
   logic                wr_drop_q, wr_drop_d;
   logic                clr_we;
   logic                usr_we;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   // ---------------------------------------------------------------------
   // Control: next state, pointer, drop pulse and array write strobes
   // ---------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      wr_drop_d = 1'b0;
      clr_we    = 1'b0;
      usr_we    = 1'b0;
      if (reset) begin
         state_d = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         ptr_d   = '0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               // The clear write owns the array; any user write is dropped.
               clr_we    = 1'b1;
               ptr_d     = ptr_q + (ADDR_W+1)'(1);
               wr_drop_d = we;
               if (ptr_q == LAST_PTR) begin
                  state_d = ST_READY;
               end
            end
            ST_READY: begin
               // Writes to the hardwired entry are silently discarded.
               usr_we = we && !((ZERO_REG != 0) && (waddr == '0));
            end
            default: begin
               state_d = ST_READY;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wr_drop_q <= wr_drop_d;
   end

   // Storage is not reset; contents are defined only by the clear sequencer
   // or by explicit writes.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem_q[ptr_q[ADDR_W-1:0]] <= '0;
      end else if (usr_we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign busy    = (state_q == ST_CLEAR);
   assign wr_drop = wr_drop_q;

   // ---------------------------------------------------------------------
   // Read ports: later assignments override earlier ones, so the order below
   // is lowest to highest priority.
   // ---------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [ADDR_W-1:0] ra;
         logic [DATA_W-1:0] rd;

         assign ra = raddr[gi*ADDR_W +: ADDR_W];

         always_comb begin
            rd = mem_q[ra];
            if ((BYPASS != 0) && we && (waddr == ra)) begin
               rd = wdata;
            end
            if ((ZERO_REG != 0) && (ra == '0)) begin
               rd = '0;
            end
            if (busy) begin
               rd = '0;
            end
         end

         assign rdata[gi*DATA_W +: DATA_W] = rd;
      end
   endgenerate

endmodule

// File: tb/tb_regfile_param.sv
// -----------------------------------------------------------------------------
// tb_regfile_param
//    Two bank instances share the write/reset stimulus:
//      dut0: NUM_RD=4, ZERO_REG=1, BYPASS=0
//      dut1: NUM_RD=2, ZERO_REG=0, BYPASS=1
//    The driver applies one transaction per cycle and pushes the expected
//    combinational/registered outputs into a queue; the monitor pops and
//    compares on the falling edge. The reference keeps plain arrays and a
//    countdown of remaining clear cycles.
// -----------------------------------------------------------------------------
module tb_regfile_param;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic            we;
   logic [AW-1:0]   waddr;
   logic [DW-1:0]   wdata;
   logic [4*AW-1:0] raddr0;
   logic [2*AW-1:0] raddr1;
   logic [4*DW-1:0] rdata0;
   logic [2*DW-1:0] rdata1;
   logic            busy0, busy1, drop0, drop1;

   always #5 clk = ~clk;

   regfile_param #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(4), .ZERO_REG(1),
                   .BYPASS(0), .CLEAR_ON_RESET(1)) dut0 (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr(raddr0), .rdata(rdata0), .busy(busy0), .wr_drop(drop0));

   regfile_param #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .ZERO_REG(0),
                   .BYPASS(1), .CLEAR_ON_RESET(1)) dut1 (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr(raddr1), .rdata(rdata1), .busy(busy1), .wr_drop(drop1));

   typedef struct packed {
      logic           busy;
      logic           wr_drop;
      logic [4*DW-1:0] r0;
      logic [2*DW-1:0] r1;
   } exp_t;

   exp_t sbq[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   txn        = 0;

   // Reference state
   logic [DW-1:0] m0 [DEPTH];
   logic [DW-1:0] m1 [DEPTH];
   int            clr_left = 0;
   logic          drop_m   = 1'b0;

   logic [AW-1:0] ra [4];
   logic [AW-1:0] rb [2];

   task automatic check(input string nm, input int port,
                        input logic [DW-1:0] act, input logic [DW-1:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s port %0d txn %0d: got %h expected %h", nm, port, txn, act, req);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         check("busy0", 0, {31'd0, busy0}, {31'd0, e.busy});
         check("busy1", 0, {31'd0, busy1}, {31'd0, e.busy});
         check("wr_drop0", 0, {31'd0, drop0}, {31'd0, e.wr_drop});
         check("wr_drop1", 0, {31'd0, drop1}, {31'd0, e.wr_drop});
         for (int i = 0; i < 4; i++)
            check("rdata0", i, rdata0[i*DW +: DW], e.r0[i*DW +: DW]);
         for (int i = 0; i < 2; i++)
            check("rdata1", i, rdata1[i*DW +: DW], e.r1[i*DW +: DW]);
      end
   end

   // One transaction: present inputs, predict outputs, advance one edge,
   // then update the reference with what that edge did.
   task automatic tick();
      exp_t e;
      raddr0 = {ra[3], ra[2], ra[1], ra[0]};
      raddr1 = {rb[1], rb[0]};
      e.busy    = (clr_left > 0);
      e.wr_drop = drop_m;
      for (int i = 0; i < 4; i++)
         e.r0[i*DW +: DW] = (clr_left > 0 || ra[i] == 0) ? '0 : m0[ra[i]];
      for (int i = 0; i < 2; i++)
         e.r1[i*DW +: DW] = (clr_left > 0) ? '0 :
                            (we && waddr == rb[i]) ? wdata : m1[rb[i]];
      sbq.push_back(e);
      txn++;
      $display("txn %0d rst=%0b we=%0b wa=%0d wd=%h ra=%0d,%0d,%0d,%0d rb=%0d,%0d busy_exp=%0b",
               txn, reset, we, waddr, wdata, ra[0], ra[1], ra[2], ra[3], rb[0], rb[1], e.busy);
      @(posedge clk);
      #1;
      if (reset) begin
         clr_left = DEPTH;
         drop_m   = 1'b0;
      end else begin
         drop_m = we && (clr_left > 0);
         if (clr_left > 0) begin
            m0[DEPTH-clr_left] = '0;
            m1[DEPTH-clr_left] = '0;
            clr_left--;
         end else if (we) begin
            if (waddr != 0) m0[waddr] = wdata;
            m1[waddr] = wdata;
         end
      end
   endtask

   task automatic drive(input logic r, input logic w, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd);
      reset = r; we = w; waddr = wa; wdata = wd;
      tick();
   endtask

   task automatic rand_reads();
      for (int i = 0; i < 4; i++) ra[i] = AW'($urandom_range(0, DEPTH-1));
      for (int i = 0; i < 2; i++) rb[i] = AW'($urandom_range(0, DEPTH-1));
   endtask

   task automatic set_reads(input int a0, input int a1, input int a2, input int a3,
                            input int b0, input int b1);
      ra[0] = AW'(a0); ra[1] = AW'(a1); ra[2] = AW'(a2); ra[3] = AW'(a3);
      rb[0] = AW'(b0); rb[1] = AW'(b1);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         rand_reads();
         drive(1'b0, 1'b0, '0, '0);
      end
   endtask

   task automatic read_all();
      for (int k = 0; k < DEPTH/4; k++) begin
         set_reads(4*k, 4*k+1, 4*k+2, 4*k+3, 4*k, 4*k+1);
         drive(1'b0, 1'b0, '0, '0);
      end
      for (int k = DEPTH/2; k < DEPTH/2 + 8; k++) begin
         set_reads(0, 0, 0, 0, 2*k-DEPTH/2, 2*k-DEPTH/2+1);
         drive(1'b0, 1'b0, '0, '0);
      end
   endtask

   initial begin
      logic [AW-1:0] wa;
      logic          w;
      // Initial reset edge, nothing predicted before it.
      reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
      set_reads(0, 0, 0, 0, 0, 0);
      raddr0 = '0; raddr1 = '0;
      @(posedge clk);
      #1;
      clr_left = DEPTH;
      drop_m   = 1'b0;

      // Power-up clear, then fill everything with a pattern.
      idle(DEPTH + 1);
      for (int a = 0; a < DEPTH; a++) begin
         rand_reads();
         drive(1'b0, 1'b1, AW'(a), 32'hA5A5A5A5);
      end
      read_all();

      // One-cycle reset pulse: full clear, every entry returns to zero.
      drive(1'b1, 1'b0, '0, '0);
      idle(DEPTH);
      read_all();

      // Write then read address 7, same cycle and next cycle.
      set_reads(0, 7, 7, 1, 3, 7);
      drive(1'b0, 1'b1, 5'd7, 32'hDEADBEEF);
      drive(1'b0, 1'b0, '0, '0);

      // Entry 0 writes: discarded on dut0, stored on dut1.
      set_reads(0, 0, 0, 0, 0, 0);
      drive(1'b0, 1'b1, 5'd0, 32'h12345678);
      drive(1'b0, 1'b0, '0, '0);

      // Write during clear cycle 4.
      drive(1'b1, 1'b0, '0, '0);
      idle(4);
      set_reads(3, 3, 3, 3, 3, 3);
      drive(1'b0, 1'b1, 5'd3, 32'h00000055);
      idle(DEPTH - 5);
      set_reads(3, 3, 3, 3, 3, 3);
      drive(1'b0, 1'b0, '0, '0);

      // Reset in the middle of a clear restarts it.
      drive(1'b1, 1'b0, '0, '0);
      idle(10);
      drive(1'b1, 1'b1, 5'd9, 32'h99999999);
      drive(1'b1, 1'b0, '0, '0);
      idle(DEPTH + 1);

      // Port independence.
      for (int a = 1; a <= 4; a++) begin
         rand_reads();
         drive(1'b0, 1'b1, AW'(a), 32'h1111_0000 + 32'(a));
      end
      set_reads(1, 2, 3, 4, 1, 2);
      drive(1'b0, 1'b0, '0, '0);
      set_reads(2, 2, 2, 2, 2, 2);
      drive(1'b0, 1'b0, '0, '0);

      // Randomized traffic with occasional resets.
      for (int k = 0; k < 400; k++) begin
         wa = AW'($urandom_range(0, DEPTH-1));
         w  = ($urandom_range(0, 1) == 1);
         rand_reads();
         for (int i = 0; i < 4; i++) if ($urandom_range(0, 3) == 0) ra[i] = wa;
         for (int i = 0; i < 2; i++) if ($urandom_range(0, 3) == 0) rb[i] = wa;
         drive(($urandom_range(0, 149) == 0), w, wa, $urandom);
      end
      drive(1'b0, 1'b0, '0, '0);

      // Let the monitor drain, bounded.
      for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk);
      if (sbq.size() != 0) begin
         mismatched++;
         $display("FAIL drain: %0d entries left, expected 0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the CPU register bank: configurable data width, depth and read-port count, with optional x0 hardwiring and optional write-to-read bypass.
- Adds a hardware clear sequencer: after reset, a state machine zeroes every entry, one per cycle, so contents are defined on real silicon, not only in simulation.
- Sits in the decode stage, feeding operands to the ALU and accepting writeback.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of independent combinational read ports (1..4)
ZERO_REG, 1, 1 = entry 0 always reads 0 and writes to it are discarded
BYPASS, 0, 1 = a read of the address being written this cycle returns write data
CLEAR_ON_RESET, 1, 1 = run the clear sequencer after reset; 0 = reset only resets control state

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
we  input  1  write enable
waddr  input  ADDR_W  write address
wdata  input  DATA_W  write data
raddr  input  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
rdata  output  NUM_RD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W]
busy  output  1  clear sequence in progress; writes ignored, reads return 0
wr_drop  output  1  registered one-cycle pulse: a write was rejected because busy was high

Behaviour:
- Reset: reset, synchronous, active-high; clock clk.
- Registered outputs after a reset edge:
  - busy = CLEAR_ON_RESET.
  - wr_drop = 0.
  - Clear pointer = 0.
- FSM has two states, CLEAR and READY.
  - Reset sampled high: state goes to CLEAR if CLEAR_ON_RESET = 1, else READY.
  - While reset stays high, state stays CLEAR with pointer 0 and no array writes.
- CLEAR sequencing:
  - Each edge with reset low writes 0 to entry[ptr], then ptr <= ptr + 1.
  - On the edge that writes entry DEPTH-1, state goes to READY and busy goes to 0.
  - busy is therefore high for exactly DEPTH edges after reset is released.
  - The pointer does not wrap.
- CLEAR_ON_RESET = 0: array contents are untouched by reset; entries are undefined until written.
- Reset asserted mid-clear restarts the sequence from pointer 0.
- Write path (READY only):
  - On an edge with we = 1, entry[waddr] <= wdata.
  - If ZERO_REG = 1 and waddr = 0, the write is discarded silently; wr_drop is not raised.
- Write while busy:
  - A write with we = 1 and busy = 1 is not performed.
  - wr_drop = 1 for the following cycle, otherwise 0.
  - The clear write has priority in all cases.
- Read path: combinational, same cycle, independent per port. Priority:
  - 1: busy = 1 gives 0.
  - 2: ZERO_REG = 1 and raddr = 0 gives 0.
  - 3: BYPASS = 1, we = 1 and waddr = raddr gives wdata.
  - 4: otherwise entry[raddr].
- BYPASS = 0: a same-cycle read of the address being written returns the old value; the new value is visible from the next cycle.
- Multiple ports may read the same address simultaneously; all return identical data.
- Width rules:
  - No arithmetic on data.
  - Pointer width is ADDR_W+1 so DEPTH is detectable without overflow.
  - Out-of-range addresses are impossible by construction.

Test Plan:
- Clear sequence: fill all entries with 0xA5A5A5A5 and check READY, pulse reset 1 cycle, then check busy for 32 cycles and read all 32 entries -> busy high exactly 32 edges after release, every entry reads 0x00000000.
- Write then read: we=1, waddr=7, wdata=0xDEADBEEF; read port 1 addr 7 same cycle (BYPASS=0) -> old value 0 in the same cycle, 0xDEADBEEF next cycle. Repeat with BYPASS=1 -> 0xDEADBEEF in the same cycle on that port.
- Zero register: write 0x12345678 to addr 0, read addr 0 on all ports -> 0 and wr_drop stays 0. With ZERO_REG=0 -> reads 0x12345678.
- Write during busy: we=1, waddr=3, wdata=0x55 at clear cycle 4 -> wr_drop=1 for one cycle, entry 3 reads 0 after clear.
- Mid-clear reset: assert reset at clear cycle 10 -> busy stays high, and a full 32-cycle clear restarts after release.
- Port independence (NUM_RD=4): entries 1..4 hold distinct values, read addresses 1,2,3,4 simultaneously -> each port returns its own entry; all ports on addr 2 -> identical data.
